// File: rtl/lut_neuron_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lut_neuron_pipe
// Brief    : Streaming lookup table with a two-stage valid/ready pipeline. It
//            runs a post-reset clear sweep and accepts runtime table writes.
//            Optional macro LUT_PARITY_EN adds per-entry even parity and m_perr.
// Revision : 1.0 - initial release
// ============================================================================
module lut_neuron_pipe #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_BITS-1:0]  s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [OUT_BITS-1:0] m_data,
  input  logic                cfg_we,
  input  logic [IN_BITS-1:0]  cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_wdata,
  output logic                init_done
`ifdef LUT_PARITY_EN
  ,
  output logic                m_perr
`endif
);

  localparam int c_DEPTH = 1 << IN_BITS;
`ifdef LUT_PARITY_EN
  localparam int c_WORD = OUT_BITS + 1;
`else
  localparam int c_WORD = OUT_BITS;
`endif

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IN_BITS-1:0]  r_clr_cnt;
  logic [c_WORD-1:0]   r_mem [c_DEPTH];
  logic                w_mem_we;
  logic [IN_BITS-1:0]  w_mem_addr;
  logic [c_WORD-1:0]   w_mem_wdata;
  logic [c_WORD-1:0]   w_cfg_word;
  logic                w_run;
  logic                w_s2_load;
  logic                w_s_fire;
  logic                r_s1_valid;
  logic [c_WORD-1:0]   r_s1_word;
  logic                r_m_valid;
  logic [OUT_BITS-1:0] r_m_data;

`ifdef LUT_PARITY_EN
  assign w_cfg_word = {^cfg_wdata, cfg_wdata};
`else
  assign w_cfg_word = cfg_wdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  // The clear sweep owns the single write port; cfg writes are only honoured in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    w_mem_addr  = cfg_addr;
    w_mem_wdata = w_cfg_word;
    if (r_state == CLEAR) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_clr_cnt;
      w_mem_wdata = '0;
      if (&r_clr_cnt) begin
        w_state_nxt = RUN;
      end
    end else begin
      w_mem_we = cfg_we;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign w_run     = (r_state == RUN);
  assign w_s2_load = !r_m_valid || m_ready;
  assign s_ready   = w_run && (!r_s1_valid || w_s2_load);
  assign w_s_fire  = s_valid && s_ready;

  // Reading at input acceptance makes a same-cycle cfg write invisible to that lookup.
  always_ff @(posedge clk) begin
    if (w_s_fire) begin
      r_s1_word <= r_mem[s_data];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
`ifdef LUT_PARITY_EN
      m_perr     <= 1'b0;
`endif
    end else begin
      if (w_s_fire) begin
        r_s1_valid <= 1'b1;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_load) begin
        r_m_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_m_data <= r_s1_word[OUT_BITS-1:0];
`ifdef LUT_PARITY_EN
          m_perr   <= ^r_s1_word;
`endif
        end
      end
    end
  end

  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign init_done = w_run;

endmodule
`default_nettype wire

// File: doc/lut_neuron_pipe.md
LUT_NEURON_PIPE -- requirements
Module: lut_neuron_pipe

Interface
REQ-001 SHALL have parameter IN_BITS, default 8, meaning the lookup address width; table depth is 2**IN_BITS.
REQ-002 SHALL have parameter OUT_BITS, default 1, meaning the width of each table entry.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 SHALL have port s_valid, input, 1 bit: input word valid.
REQ-006 SHALL have port s_ready, output, 1 bit: block accepts an input word.
REQ-007 SHALL have port s_data, input, IN_BITS bits: the lookup address.
REQ-008 SHALL have port m_valid, output, 1 bit: result valid.
REQ-009 SHALL have port m_ready, input, 1 bit: downstream accepts the result.
REQ-010 SHALL have port m_data, output, OUT_BITS bits: the table entry addressed by s_data.
REQ-011 SHALL have port cfg_we, input, 1 bit: table write strobe.
REQ-012 SHALL have port cfg_addr, input, IN_BITS bits: table write address.
REQ-013 SHALL have port cfg_wdata, input, OUT_BITS bits: table write data.
REQ-014 SHALL have port init_done, output, 1 bit: high once the post-reset table clear has completed.

Function
REQ-015 SHALL implement a state machine with states CLEAR and RUN; reset enters CLEAR.
REQ-016 In CLEAR, SHALL write zero to one entry per cycle, using a counter from 0 to 2**IN_BITS-1, and enter RUN on the cycle after the last entry is written.
REQ-017 In CLEAR, SHALL hold s_ready=0, init_done=0, and ignore cfg_we.
REQ-018 In RUN, SHALL hold init_done=1 and write cfg_wdata to cfg_addr on each cycle with cfg_we=1.
REQ-019 SHALL transfer an input word on a cycle with s_valid=1 and s_ready=1, and transfer a result on a cycle with m_valid=1 and m_ready=1.
REQ-020 SHALL be a two-stage pipeline: an address register, then an output register; latency is 2 cycles from input transfer to m_valid assertion with m_ready held high.
REQ-021 SHALL sustain one transfer per cycle while m_ready=1.
REQ-022 SHALL drive s_ready = RUN and (stage-1 empty, or stage-1 advancing this cycle).
REQ-023 SHALL keep m_data and m_valid stable while m_valid=1 and m_ready=0; no result is dropped or duplicated.
REQ-024 When a cfg write and a lookup target the same address in the same cycle, the lookup SHALL return the pre-write value, and later lookups SHALL return the new value.
REQ-025 Table contents SHALL change only through CLEAR or cfg writes; results preserve input order.

Reset
REQ-026 Asserting rst SHALL immediately force: state CLEAR, clear counter 0, both pipeline valids 0, m_valid=0, m_data=0, s_ready=0, init_done=0.
REQ-027 rst asserted mid-RUN SHALL discard in-flight words, and the clear sweep SHALL restart from address 0 after deassertion.
REQ-028 The table storage itself SHALL NOT be asynchronously reset; it is zeroed by the CLEAR sweep only.

Configuration
REQ-029 Macro LUT_PARITY_EN: when defined, each entry SHALL store an even-parity bit computed on write, and an output port m_perr (1 bit) SHALL be registered alongside m_data, high when the stored parity mismatches the read entry; m_perr resets to 0.
REQ-030 When LUT_PARITY_EN is undefined, no parity storage and no m_perr port SHALL exist; all other behaviour is identical.

Verification
REQ-031 IN_BITS=8, OUT_BITS=1: release reset -> init_done rises after exactly 256 cycles; lookup of any address returns 0.
REQ-032 After init, cfg write 0x70->1 and 0x48->1; stream inputs 0x70,0x48,0x00 with m_ready=1 -> m_data 1,1,0 on consecutive cycles, first result 2 cycles after input.
REQ-033 Streaming inputs with m_ready toggled 1,0,0,1 -> s_ready drops once both stages are full, m_data is held stable, and all results arrive in order with none lost.
REQ-034 Same cycle: cfg write addr 0x10 data 1 and lookup 0x10 -> result 0; next lookup of 0x10 -> result 1.
REQ-035 Assert rst with 2 words in flight -> m_valid is 0 immediately, no stale result appears, and a fresh 256-cycle clear sweep runs.
REQ-036 With LUT_PARITY_EN defined, force a bit flip in the stored entry at 0x05, then look up 0x05 -> m_perr=1 with the result; look up an unflipped entry -> m_perr=0.
